cam_responder: RTL and testbench
================================

CAM_RESPONDER -- requirements
Module: cam_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 64: key width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: log2 of entry count; N = 2**ADDR_WIDTH entries.
REQ-003 Parameter WRITE_CYCLES, default 2, legal range 1..15: number of BUSY-state cycles per write.
REQ-004 clk  in  1  clock; all state updates occur on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 write_addr  in  ADDR_WIDTH  target entry index.
REQ-007 write_data  in  DATA_WIDTH  key to store.
REQ-008 write_delete  in  1  1 = invalidate the entry; 0 = store the key.
REQ-009 write_enable  in  1  write request, sampled only in IDLE.
REQ-010 write_busy  out  1  write in progress; new requests are not accepted.
REQ-011 compare_data  in  DATA_WIDTH  search key, sampled every cycle.
REQ-012 match_many  out  N  bit i = entry i valid and equal to the key.
REQ-013 match_single  out  N  one-hot bit for the lowest-index match; all zeros if there is no match.
REQ-014 match_addr  out  ADDR_WIDTH  index of the lowest matching entry; 0 if there is no match.
REQ-015 match  out  1  1 if any entry matches.

Function
REQ-016 Storage: N key registers, each with a valid bit.
REQ-017 The write FSM has three states, IDLE, BUSY and COMMIT, with write_busy = (state != IDLE).
REQ-018 IDLE with write_enable=1: capture addr/data/delete, load the cycle counter with WRITE_CYCLES-1, move to BUSY.
REQ-019 BUSY: decrement the counter each cycle; move to COMMIT in the cycle the counter is 0.
REQ-020 COMMIT: apply the write in that cycle, then return to IDLE.
  - delete=0: key <= data, valid <= 1.
  - delete=1: valid <= 0; the key is left unchanged.
REQ-021 write_busy goes high the cycle after acceptance and stays high for WRITE_CYCLES+1 cycles.
REQ-022 write_enable while write_busy=1 is ignored; the captured request is not altered.
REQ-023 Back-to-back writes: a request held high during the IDLE cycle after COMMIT is accepted in that IDLE cycle.
REQ-024 Writing an address that is already valid overwrites it.
REQ-025 Deleting an invalid entry has no effect other than consuming the busy window.
REQ-026 Compare latency is 1 cycle: all match outputs are registered from compare_data and the array contents present before the same edge.
REQ-027 Compare in the COMMIT cycle sees pre-write contents; the updated entry affects results sampled from the next cycle on.
REQ-028 Duplicate keys set several match_many bits; match_single, match_addr and match reflect the lowest index.
REQ-029 Invalid entries never match, whatever key value they hold.

Reset
REQ-030 rst=1 asynchronously forces the following, regardless of FSM state; a write in progress at reset is discarded:
  - FSM to IDLE, counter to 0;
  - every valid bit and key to 0;
  - write_busy, match_many, match_single, match_addr and match to 0.
REQ-031 After rst falls, the first request is accepted at the first rising edge with write_enable=1.

Configuration
REQ-032 Macro CAM_RESPONDER_DROP_CNT_EN:
  - Defined: adds output drop_cnt, 16 bits, reset 0. It increments by 1 for each cycle with write_enable=1 and write_busy=1, and saturates at 16'hFFFF.
  - Undefined: the port and counter do not exist, and all other behaviour is identical.

Structure
REQ-033 Package cam_pkg holds:
  - the FSM state enum (IDLE, BUSY, COMMIT);
  - default constants for DATA_WIDTH and ADDR_WIDTH;
  - the drop counter width, 16.
REQ-034 Sub-module cam_prio_enc, parameterised by ADDR_WIDTH, is purely combinational. It maps match_many to match_single, match_addr and match.

Verification
REQ-035 Reset, then write addr 3 / data 64'hA5 / delete 0.
  - write_busy is high for exactly 3 cycles.
  - After that, compare 64'hA5 gives match=1, match_addr=3, match_many=32'h8 one cycle later.
REQ-036 Keys 64'h77 at addr 5 and addr 2.
  - Compare 64'h77 gives match_many=32'h24, match_single=32'h4, match_addr=2.
REQ-037 Delete addr 2.
  - Compare 64'h77 gives match_addr=5, match_single=32'h20.
  - Compare of a never-written key gives match=0, match_addr=0.
REQ-038 Hold compare 64'h99 every cycle while writing 64'h99 to addr 7.
  - match is 0 through the COMMIT cycle and goes to 1 the cycle after.
REQ-039 Pulse write_enable for 2 cycles during busy with different addr/data.
  - Only the original write commits.
  - With CAM_RESPONDER_DROP_CNT_EN defined, drop_cnt=2.
REQ-040 Assert rst in the BUSY state of a write to addr 9.
  - All outputs are 0 immediately.
  - After release, compare of the written key gives match=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and defaults for the CAM responder slice.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        COMMIT
    } wr_state_e;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DROP_CNT_W     = 16;
    localparam int WCNT_W         = 4;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over the CAM hit vector.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [(1<<ADDR_WIDTH)-1:0] match_many,
    output logic [(1<<ADDR_WIDTH)-1:0] match_single,
    output logic [ADDR_WIDTH-1:0]      match_addr,
    output logic                       match
);

    localparam int N = 1 << ADDR_WIDTH;

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        match_single = '0;
        match_addr   = '0;
        match        = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (match_many[i]) begin
                match_single    = '0;
                match_single[i] = 1'b1;
                match_addr      = ADDR_WIDTH'(i);
                match           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_responder.sv
// Content-addressable memory with a multi-cycle write FSM and 1-cycle compare.
// Optional drop counter enabled by CAM_RESPONDER_DROP_CNT_EN.
module cam_responder
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      write_addr,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       write_delete,
    input  logic                       write_enable,
    output logic                       write_busy,
    input  logic [DATA_WIDTH-1:0]      compare_data,
    output logic [(1<<ADDR_WIDTH)-1:0] match_many,
    output logic [(1<<ADDR_WIDTH)-1:0] match_single,
    output logic [ADDR_WIDTH-1:0]      match_addr,
    output logic                       match
`ifdef CAM_RESPONDER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]      drop_cnt
`endif
);

    localparam int N = 1 << ADDR_WIDTH;

    wr_state_e             state;
    logic [WCNT_W-1:0]     cnt;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_delete;

    logic [DATA_WIDTH-1:0] keys [N];
    logic [N-1:0]          valid;

    logic [N-1:0]          hit;
    logic [N-1:0]          hit_single;
    logic [ADDR_WIDTH-1:0] hit_addr;
    logic                  hit_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            req_delete <= 1'b0;
            write_busy <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (write_enable) begin
                        req_addr   <= write_addr;
                        req_data   <= write_data;
                        req_delete <= write_delete;
                        cnt        <= WCNT_W'(WRITE_CYCLES - 1);
                        state      <= BUSY;
                        write_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                COMMIT: begin
                    state      <= IDLE;
                    write_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    write_busy <= 1'b0;
                end
            endcase
        end
    end

    // A delete only clears the valid bit; the stale key stays behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < N; i++) begin
                keys[i] <= '0;
            end
        end else if (state == COMMIT) begin
            if (req_delete) begin
                valid[req_addr] <= 1'b0;
            end else begin
                valid[req_addr] <= 1'b1;
                keys[req_addr]  <= req_data;
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = valid[i] && (keys[i] == compare_data);
        end
    end

    cam_prio_enc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio (
        .match_many   (hit),
        .match_single (hit_single),
        .match_addr   (hit_addr),
        .match        (hit_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_many   <= '0;
            match_single <= '0;
            match_addr   <= '0;
            match        <= 1'b0;
        end else begin
            match_many   <= hit;
            match_single <= hit_single;
            match_addr   <= hit_addr;
            match        <= hit_any;
        end
    end

`ifdef CAM_RESPONDER_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (write_enable && write_busy && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cam_responder.sv
// Scoreboard bench for cam_responder: directed writes, compares and resets.
module tb_cam_responder;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          write_delete;
    logic          write_enable;
    logic          write_busy;
    logic [DW-1:0] compare_data;
    logic [N-1:0]  match_many;
    logic [N-1:0]  match_single;
    logic [AW-1:0] match_addr;
    logic          match;
`ifdef CAM_RESPONDER_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    cam_responder #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .WRITE_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_delete (write_delete),
        .write_enable (write_enable),
        .write_busy   (write_busy),
        .compare_data (compare_data),
        .match_many   (match_many),
        .match_single (match_single),
        .match_addr   (match_addr),
        .match        (match)
`ifdef CAM_RESPONDER_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    localparam int S_MATCH  = 0;
    localparam int S_ADDR   = 1;
    localparam int S_MANY   = 2;
    localparam int S_SINGLE = 3;
    localparam int S_BUSY   = 4;
    localparam int S_DROP   = 5;

    typedef struct {
        int          due;
        int          sel;
        logic [63:0] exp;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pick(int sel);
        case (sel)
            S_MATCH:  return 64'(match);
            S_ADDR:   return 64'(match_addr);
            S_MANY:   return 64'(match_many);
            S_SINGLE: return 64'(match_single);
            S_BUSY:   return 64'(write_busy);
`ifdef CAM_RESPONDER_DROP_CNT_EN
            S_DROP:   return 64'(drop_cnt);
`endif
            default:  return 64'hx;
        endcase
    endfunction

    // Monitor: retire every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due <= cyc) begin
                logic [63:0] act;
                checks++;
                if (sbq[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s: not sampled in cycle %0d", sbq[i].nm, sbq[i].due);
                end else begin
                    act = pick(sbq[i].sel);
                    if (act !== sbq[i].exp) begin
                        errors++;
                        $display("FAIL %s: got %0h expected %0h", sbq[i].nm, act, sbq[i].exp);
                    end
                end
                sbq.delete(i);
            end
        end
    end

    task automatic push(int due, int sel, logic [63:0] v, string nm);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.exp = v;
        e.nm  = nm;
        sbq.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d, logic del, bit chk, string nm);
        int c;
        c            = cyc;
        write_addr   = a;
        write_data   = d;
        write_delete = del;
        write_enable = 1'b1;
        if (chk) begin
            push(c,     S_BUSY, 64'd0, {nm, ".busy_pre"});
            push(c + 1, S_BUSY, 64'd1, {nm, ".busy1"});
            push(c + 2, S_BUSY, 64'd1, {nm, ".busy2"});
            push(c + 3, S_BUSY, 64'd1, {nm, ".busy3"});
            push(c + 4, S_BUSY, 64'd0, {nm, ".busy_end"});
        end
        step(1);
        write_enable = 1'b0;
        step(3);
    endtask

    task automatic cmp(logic [DW-1:0] k, logic m, logic [AW-1:0] ad,
                       logic [N-1:0] many, logic [N-1:0] single, string nm);
        int c;
        c            = cyc;
        compare_data = k;
        push(c + 1, S_MATCH,  64'(m),      {nm, ".match"});
        push(c + 1, S_ADDR,   64'(ad),     {nm, ".addr"});
        push(c + 1, S_MANY,   64'(many),   {nm, ".many"});
        push(c + 1, S_SINGLE, 64'(single), {nm, ".single"});
        step(1);
    endtask

    task automatic zero_checks(string nm);
        push(cyc, S_BUSY,   64'd0, {nm, ".busy"});
        push(cyc, S_MATCH,  64'd0, {nm, ".match"});
        push(cyc, S_ADDR,   64'd0, {nm, ".addr"});
        push(cyc, S_MANY,   64'd0, {nm, ".many"});
        push(cyc, S_SINGLE, 64'd0, {nm, ".single"});
`ifdef CAM_RESPONDER_DROP_CNT_EN
        push(cyc, S_DROP,   64'd0, {nm, ".drop"});
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst          = 1'b1;
        write_addr   = '0;
        write_data   = '0;
        write_delete = 1'b0;
        write_enable = 1'b0;
        compare_data = '0;

        step(1);
        zero_checks("reset");
        step(1);
        rst = 1'b0;
        step(1);

        cmp(64'h0, 1'b0, 5'd0, 32'h0, 32'h0, "zero_key_invalid");

        wr(5'd3, 64'hA5, 1'b0, 1'b1, "wr3");
        cmp(64'hA5, 1'b1, 5'd3, 32'h8, 32'h8, "hit3");

        wr(5'd5, 64'h77, 1'b0, 1'b0, "wr5");
        wr(5'd2, 64'h77, 1'b0, 1'b0, "wr2");
        cmp(64'h77, 1'b1, 5'd2, 32'h24, 32'h4, "dup77");

        wr(5'd2, 64'h0, 1'b1, 1'b1, "del2");
        cmp(64'h77, 1'b1, 5'd5, 32'h20, 32'h20, "after_del");
        cmp(64'h1234, 1'b0, 5'd0, 32'h0, 32'h0, "never_written");

        wr(5'd20, 64'h0, 1'b1, 1'b0, "del_invalid");
        cmp(64'hA5, 1'b1, 5'd3, 32'h8, 32'h8, "still3");

        wr(5'd5, 64'h88, 1'b0, 1'b0, "over5");
        cmp(64'h77, 1'b0, 5'd0, 32'h0, 32'h0, "old77_gone");
        cmp(64'h88, 1'b1, 5'd5, 32'h20, 32'h20, "new88");

        // Compare held across the write to addr 7.
        c            = cyc;
        compare_data = 64'h99;
        write_addr   = 5'd7;
        write_data   = 64'h99;
        write_delete = 1'b0;
        write_enable = 1'b1;
        push(c + 1, S_MATCH, 64'd0, "hold99.busy1");
        push(c + 2, S_MATCH, 64'd0, "hold99.busy2");
        push(c + 3, S_MATCH, 64'd0, "hold99.commit");
        push(c + 5, S_MATCH, 64'd1, "hold99.after");
        push(c + 5, S_ADDR,  64'd7, "hold99.addr");
        step(1);
        write_enable = 1'b0;
        step(5);

        // Requests during busy must be dropped.
        c            = cyc;
        write_addr   = 5'd4;
        write_data   = 64'h44;
        write_enable = 1'b1;
        step(1);
        write_addr   = 5'd10;
        write_data   = 64'h55;
        step(2);
        write_enable = 1'b0;
        step(1);
`ifdef CAM_RESPONDER_DROP_CNT_EN
        push(cyc, S_DROP, 64'd2, "drop_cnt");
`endif
        cmp(64'h55, 1'b0, 5'd0, 32'h0, 32'h0, "dropped55");
        cmp(64'h44, 1'b1, 5'd4, 32'h10, 32'h10, "kept44");

        // Back-to-back: enable held into the IDLE cycle after COMMIT.
        c            = cyc;
        write_addr   = 5'd12;
        write_data   = 64'hC1;
        write_enable = 1'b1;
        step(1);
        write_addr   = 5'd13;
        write_data   = 64'hC2;
        push(c + 4, S_BUSY, 64'd0, "b2b.idle");
        push(c + 5, S_BUSY, 64'd1, "b2b.busy");
        step(4);
        write_enable = 1'b0;
        step(3);
        cmp(64'hC1, 1'b1, 5'd12, 32'h1000, 32'h1000, "b2b_first");
        cmp(64'hC2, 1'b1, 5'd13, 32'h2000, 32'h2000, "b2b_second");

        // Reset in the middle of a write to addr 9.
        cmp(64'h44, 1'b1, 5'd4, 32'h10, 32'h10, "pre_rst44");
        write_addr   = 5'd9;
        write_data   = 64'hBEEF;
        write_enable = 1'b1;
        step(1);
        write_enable = 1'b0;
        rst          = 1'b1;
        #1;
        zero_checks("mid_rst");
        step(1);
        rst = 1'b0;
        step(1);
        push(cyc, S_BUSY, 64'd0, "post_rst.busy");
        cmp(64'hBEEF, 1'b0, 5'd0, 32'h0, 32'h0, "discarded9");
        cmp(64'h44, 1'b0, 5'd0, 32'h0, 32'h0, "cleared44");

        for (int i = 0; i < 10 && sbq.size() > 0; i++) step(1);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
